// File: rtl/board_render_datapath_if.sv
// Command, cursor-move and VGA pixel-write signals between the game control FSM,
// the board datapath and the frame-buffer adapter.
interface board_render_datapath_if;
  logic       plot_empty;
  logic       draw_cell;
  logic       place_disk;
  logic       turn_side;
  logic       move_up;
  logic       move_down;
  logic       move_left;
  logic       move_right;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       placed;
  logic       rejected;
  logic [2:0] cursor_col;
  logic [2:0] cursor_row;
  logic [1:0] cursor_cell;

  modport master (
    output plot_empty, draw_cell, place_disk, turn_side,
    output move_up, move_down, move_left, move_right,
    input  vga_x, vga_y, vga_colour, vga_plot,
    input  busy, placed, rejected, cursor_col, cursor_row, cursor_cell
  );

  modport slave (
    input  plot_empty, draw_cell, place_disk, turn_side,
    input  move_up, move_down, move_left, move_right,
    output vga_x, vga_y, vga_colour, vga_plot,
    output busy, placed, rejected, cursor_col, cursor_row, cursor_cell
  );
endinterface

// File: rtl/board_render_datapath.sv
// Othello board state, cursor and per-cell pixel renderer for a 160x120 3-bit VGA frame buffer.
// Define CURSOR_WRAP_EN to make cursor moves wrap modulo 8 instead of saturating at 0 and 7.
module board_render_datapath #(
  parameter int CELL_PX  = 14,
  parameter int ORIGIN_X = 24,
  parameter int ORIGIN_Y = 4
) (
  input logic                    clk,
  input logic                    restart,
  board_render_datapath_if.slave bus
);

  // state  | meaning
  // IDLE   | waiting for a command edge or a pending command
  // LOAD   | latch cell origin and content; place_disk writes or rejects here
  // DRAW   | one pixel per cycle, raster over the cell
  // DONE   | job finished; plot_empty applies latched cursor moves
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_EMPTY, CMD_DRAW, CMD_PLACE} cmd_t;

  localparam logic [3:0] LAST = 4'(CELL_PX - 1);

  state_t     state, state_n;
  cmd_t       new_cmd, start_cmd, pend_cmd, job_cmd;
  logic       start_side, pend_side, job_side;
  logic       prev_empty, prev_draw, prev_place;
  logic       e_empty, e_draw, e_place;
  logic [1:0] board [8][8];
  logic [2:0] cur_row, cur_col, row_n, col_n;
  logic [3:0] mv_lat;
  logic [1:0] cell_here, job_cell, side_code;
  logic [7:0] org_x;
  logic [6:0] org_y;
  logic [3:0] px, py;
  logic       place_ok, place_bad, border;
  logic [2:0] colour;

  assign e_empty = bus.plot_empty & ~prev_empty;
  assign e_draw  = bus.draw_cell  & ~prev_draw;
  assign e_place = bus.place_disk & ~prev_place;

  always_comb begin
    new_cmd = CMD_NONE;
    if (e_place)      new_cmd = CMD_PLACE;
    else if (e_empty) new_cmd = CMD_EMPTY;
    else if (e_draw)  new_cmd = CMD_DRAW;
  end

  assign cell_here = board[cur_row][cur_col];
  assign side_code = job_side ? 2'b10 : 2'b01;
  assign place_ok  = (state == S_LOAD) && (job_cmd == CMD_PLACE) && (cell_here == 2'b00);
  assign place_bad = (state == S_LOAD) && (job_cmd == CMD_PLACE) && (cell_here != 2'b00);

  always_ff @(posedge clk or posedge restart) begin
    if (restart) state <= S_IDLE;
    else         state <= state_n;
  end

  // A pending command takes precedence over a fresh edge when leaving IDLE.
  always_comb begin
    state_n    = state;
    start_cmd  = CMD_NONE;
    start_side = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_cmd != CMD_NONE) begin
          start_cmd  = pend_cmd;
          start_side = pend_side;
        end else begin
          start_cmd  = new_cmd;
          start_side = bus.turn_side;
        end
        if (start_cmd != CMD_NONE) state_n = S_LOAD;
      end
      S_LOAD:  state_n = place_bad ? S_DONE : S_DRAW;
      S_DRAW:  if (px == LAST && py == LAST) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      prev_empty <= 1'b0;
      prev_draw  <= 1'b0;
      prev_place <= 1'b0;
    end else begin
      prev_empty <= bus.plot_empty;
      prev_draw  <= bus.draw_cell;
      prev_place <= bus.place_disk;
    end
  end

  // One-deep slot; a stored place_disk is never displaced by a later edge.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      pend_cmd  <= CMD_NONE;
      pend_side <= 1'b0;
    end else if (state == S_IDLE) begin
      if (pend_cmd != CMD_NONE) begin
        pend_cmd  <= new_cmd;
        pend_side <= bus.turn_side;
      end
    end else if (new_cmd != CMD_NONE && pend_cmd != CMD_PLACE) begin
      pend_cmd  <= new_cmd;
      pend_side <= bus.turn_side;
    end
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      job_cmd  <= CMD_NONE;
      job_side <= 1'b0;
      job_cell <= 2'b00;
      org_x    <= 8'd0;
      org_y    <= 7'd0;
      px       <= 4'd0;
      py       <= 4'd0;
    end else begin
      if (state == S_IDLE && start_cmd != CMD_NONE) begin
        job_cmd  <= start_cmd;
        job_side <= start_side;
      end
      if (state == S_LOAD) begin
        org_x    <= 8'(ORIGIN_X) + 8'(cur_col) * 8'(CELL_PX);
        org_y    <= 7'(ORIGIN_Y) + 7'(cur_row) * 7'(CELL_PX);
        job_cell <= place_ok ? side_code : cell_here;
        px       <= 4'd0;
        py       <= 4'd0;
      end else if (state == S_DRAW) begin
        if (px == LAST) begin
          px <= 4'd0;
          py <= py + 4'd1;
        end else begin
          px <= px + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          board[r[2:0]][c[2:0]] <= 2'b00;
      board[3][3] <= 2'b10;
      board[4][4] <= 2'b10;
      board[3][4] <= 2'b01;
      board[4][3] <= 2'b01;
    end else if (place_ok) begin
      board[cur_row][cur_col] <= side_code;
    end
  end

  function automatic logic [2:0] step(input logic [2:0] pos, input logic dec, input logic inc);
    logic [2:0] res;
    res = pos;
    if (inc && !dec) begin
`ifdef CURSOR_WRAP_EN
      res = pos + 3'd1;
`else
      if (pos != 3'd7) res = pos + 3'd1;
`endif
    end else if (dec && !inc) begin
`ifdef CURSOR_WRAP_EN
      res = pos - 3'd1;
`else
      if (pos != 3'd0) res = pos - 3'd1;
`endif
    end
    return res;
  endfunction

  // mv_lat = {up, down, left, right}
  assign row_n = step(cur_row, mv_lat[3], mv_lat[2]);
  assign col_n = step(cur_col, mv_lat[1], mv_lat[0]);

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      cur_row <= 3'd0;
      cur_col <= 3'd0;
      mv_lat  <= 4'd0;
    end else if (state == S_DONE && job_cmd == CMD_EMPTY) begin
      cur_row <= row_n;
      cur_col <= col_n;
      mv_lat  <= 4'd0;
    end else begin
      mv_lat <= mv_lat | {bus.move_up, bus.move_down, bus.move_left, bus.move_right};
    end
  end

  assign border = (px == 4'd0) || (py == 4'd0) || (px == LAST) || (py == LAST);

  always_comb begin
    colour = 3'b010;
    if (border) begin
      colour = (job_cmd == CMD_EMPTY) ? 3'b001 : 3'b110;
    end else begin
      case (job_cell)
        2'b01:   colour = 3'b000;
        2'b10:   colour = 3'b111;
        default: colour = 3'b010;
      endcase
    end
  end

  assign bus.vga_plot    = (state == S_DRAW);
  assign bus.vga_x       = bus.vga_plot ? org_x + {4'b0000, px} : 8'd0;
  assign bus.vga_y       = bus.vga_plot ? org_y + {3'b000, py} : 7'd0;
  assign bus.vga_colour  = bus.vga_plot ? colour : 3'b000;
  assign bus.busy        = (state != S_IDLE);
  assign bus.placed      = place_ok;
  assign bus.rejected    = place_bad;
  assign bus.cursor_col  = cur_col;
  assign bus.cursor_row  = cur_row;
  assign bus.cursor_cell = cell_here;

endmodule

// File: tb/tb_board_render_datapath.sv
// Directed bench for board_render_datapath: a table of command jobs with hand-computed
// pixel/colour/timing expectations, then hand-written queueing, priority and reset sequences.
module tb_board_render_datapath;
  localparam int CP = 14;
`ifdef CURSOR_WRAP_EN
  localparam int C7 = 0;
`else
  localparam int C7 = 7;
`endif
  localparam logic [2:0] DRW = 3'b001;
  localparam logic [2:0] EMP = 3'b010;
  localparam logic [2:0] PLC = 3'b100;

  logic clk;
  logic restart;
  board_render_datapath_if bus ();

  board_render_datapath #(.CELL_PX(CP), .ORIGIN_X(24), .ORIGIN_Y(4)) dut (
    .clk(clk), .restart(restart), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cmds;      // {place, empty, draw}
    logic       side;
    logic [3:0] mv;        // {up, down, left, right}
    int         at_col, at_row;
    int         plots, fall;
    logic [2:0] border, interior;
    int         placed, rejected;
    int         end_col, end_row;
    logic [1:0] end_cell;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[18];

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] cmds, input logic side, input logic [3:0] mv,
                              input int ac, input int ar, input int pl, input int fa,
                              input logic [2:0] bo, input logic [2:0] inr,
                              input int np, input int nr, input int ec, input int er,
                              input logic [1:0] ecell);
    vec_t v;
    v.cmds = cmds; v.side = side; v.mv = mv; v.at_col = ac; v.at_row = ar;
    v.plots = pl; v.fall = fa; v.border = bo; v.interior = inr;
    v.placed = np; v.rejected = nr; v.end_col = ec; v.end_row = er; v.end_cell = ecell;
    return v;
  endfunction

  task automatic drive_cmds(input logic [2:0] m);
    bus.place_disk = m[2];
    bus.plot_empty = m[1];
    bus.draw_cell  = m[0];
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    int plots = 0, bad_xy = 0, bad_col = 0, np = 0, nr = 0, fall = -1, px, py;
    logic [2:0] ec;
    if (t.mv != 4'b0000) begin
      @(negedge clk);
      {bus.move_up, bus.move_down, bus.move_left, bus.move_right} = t.mv;
      @(negedge clk);
      {bus.move_up, bus.move_down, bus.move_left, bus.move_right} = 4'b0000;
    end
    @(negedge clk);
    bus.turn_side = t.side;
    drive_cmds(t.cmds);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) drive_cmds(3'b000);
      if (bus.vga_plot) begin
        px = plots % CP;
        py = plots / CP;
        if (int'(bus.vga_x) != 24 + t.at_col * CP + px || int'(bus.vga_y) != 4 + t.at_row * CP + py)
          bad_xy++;
        ec = (px == 0 || py == 0 || px == CP - 1 || py == CP - 1) ? t.border : t.interior;
        if (bus.vga_colour != ec) bad_col++;
        plots++;
      end
      if (bus.placed) np++;
      if (bus.rejected) nr++;
      if (!bus.busy) begin
        fall = k;
        break;
      end
    end
    check("plots", idx, plots, t.plots);
    check("busy_fall", idx, fall, t.fall);
    check("bad_xy", idx, bad_xy, 0);
    check("bad_colour", idx, bad_col, 0);
    check("placed", idx, np, t.placed);
    check("rejected", idx, nr, t.rejected);
    check("cursor_col", idx, int'(bus.cursor_col), t.end_col);
    check("cursor_row", idx, int'(bus.cursor_row), t.end_row);
    check("cursor_cell", idx, int'(bus.cursor_cell), int'(t.end_cell));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int plots, n001, n110, last, np, nr;
    logic prev_busy;

    restart = 1'b1;
    drive_cmds(3'b000);
    bus.turn_side = 1'b0;
    {bus.move_up, bus.move_down, bus.move_left, bus.move_right} = 4'b0000;

    vecs[0]  = mk(DRW, 0, 4'b0000, 0, 0, 196, 199, 3'b110, 3'b010, 0, 0, 0, 0, 2'b00);
    vecs[1]  = mk(EMP, 0, 4'b0001, 0, 0, 196, 199, 3'b001, 3'b010, 0, 0, 1, 0, 2'b00);
    vecs[2]  = mk(DRW, 0, 4'b0000, 1, 0, 196, 199, 3'b110, 3'b010, 0, 0, 1, 0, 2'b00);
    vecs[3]  = mk(EMP, 0, 4'b0101, 1, 0, 196, 199, 3'b001, 3'b010, 0, 0, 2, 1, 2'b00);
    vecs[4]  = mk(EMP, 0, 4'b0100, 2, 1, 196, 199, 3'b001, 3'b010, 0, 0, 2, 2, 2'b00);
    vecs[5]  = mk(PLC, 1, 4'b0000, 2, 2, 196, 199, 3'b110, 3'b111, 1, 0, 2, 2, 2'b10);
    vecs[6]  = mk(PLC, 0, 4'b0000, 2, 2, 0,   3,   3'b110, 3'b010, 0, 1, 2, 2, 2'b10);
    vecs[7]  = mk(EMP, 0, 4'b1101, 2, 2, 196, 199, 3'b001, 3'b111, 0, 0, 3, 2, 2'b00);
    vecs[8]  = mk(EMP, 0, 4'b0100, 3, 2, 196, 199, 3'b001, 3'b010, 0, 0, 3, 3, 2'b10);
    vecs[9]  = mk(EMP, 0, 4'b0001, 3, 3, 196, 199, 3'b001, 3'b111, 0, 0, 4, 3, 2'b01);
    vecs[10] = mk(DRW, 0, 4'b0000, 4, 3, 196, 199, 3'b110, 3'b000, 0, 0, 4, 3, 2'b01);
    vecs[11] = mk(EMP, 0, 4'b0001, 4, 3, 196, 199, 3'b001, 3'b000, 0, 0, 5, 3, 2'b00);
    vecs[12] = mk(EMP, 0, 4'b0001, 5, 3, 196, 199, 3'b001, 3'b010, 0, 0, 6, 3, 2'b00);
    vecs[13] = mk(EMP, 0, 4'b0001, 6, 3, 196, 199, 3'b001, 3'b010, 0, 0, 7, 3, 2'b00);
    vecs[14] = mk(EMP, 0, 4'b0001, 7, 3, 196, 199, 3'b001, 3'b010, 0, 0, C7, 3, 2'b00);
    vecs[15] = mk(PLC | DRW, 0, 4'b0000, C7, 3, 196, 199, 3'b110, 3'b000, 1, 0, C7, 3, 2'b01);
    vecs[16] = mk(EMP | DRW, 0, 4'b0000, C7, 3, 196, 199, 3'b001, 3'b000, 0, 0, C7, 3, 2'b01);
    vecs[17] = mk(EMP, 0, 4'b1011, C7, 3, 196, 199, 3'b001, 3'b000, 0, 0, C7, 2, 2'b00);

    repeat (3) @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
    check("rst_cursor_col", 0, int'(bus.cursor_col), 0);
    check("rst_cursor_row", 0, int'(bus.cursor_row), 0);
    check("rst_cursor_cell", 0, int'(bus.cursor_cell), 0);
    check("rst_busy", 0, int'(bus.busy), 0);
    check("rst_plot", 0, int'(bus.vga_plot), 0);
    check("rst_vga_x", 0, int'(bus.vga_x), 0);
    check("rst_placed", 0, int'(bus.placed), 0);

    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

    // plot_empty job with a draw_cell edge arriving mid-job: both jobs run back to back
    @(negedge clk);
    bus.plot_empty = 1'b1;
    plots = 0; n001 = 0; n110 = 0; last = -1; prev_busy = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (k == 1)  bus.plot_empty = 1'b0;
      if (k == 10) bus.draw_cell = 1'b1;
      if (k == 11) bus.draw_cell = 1'b0;
      if (bus.vga_plot) begin
        plots++;
        if (bus.vga_colour == 3'b001) n001++;
        if (bus.vga_colour == 3'b110) n110++;
      end
      if (bus.busy) last = k;
      else if (!prev_busy) break;
      prev_busy = bus.busy;
    end
    check("queue_plots", 100, plots, 392);
    check("queue_border001", 100, n001, 52);
    check("queue_border110", 100, n110, 52);
    check("queue_last_busy", 100, last, 397);
    check("queue_cursor_col", 100, int'(bus.cursor_col), C7);

    // held draw_cell level triggers exactly one job
    @(negedge clk);
    bus.draw_cell = 1'b1;
    plots = 0;
    for (int k = 1; k <= 450; k++) begin
      @(negedge clk);
      if (bus.vga_plot) plots++;
    end
    bus.draw_cell = 1'b0;
    check("held_plots", 101, plots, 196);
    check("held_busy", 101, int'(bus.busy), 0);

    // pending place_disk survives a later draw_cell edge
    @(negedge clk);
    bus.draw_cell = 1'b1;
    plots = 0; np = 0; nr = 0; last = -1; prev_busy = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (k == 1) bus.draw_cell = 1'b0;
      if (k == 5) begin bus.turn_side = 1'b1; bus.place_disk = 1'b1; end
      if (k == 6) bus.place_disk = 1'b0;
      if (k == 8) bus.draw_cell = 1'b1;
      if (k == 9) bus.draw_cell = 1'b0;
      if (bus.vga_plot) plots++;
      if (bus.placed) np++;
      if (bus.rejected) nr++;
      if (bus.busy) last = k;
      else if (!prev_busy) break;
      prev_busy = bus.busy;
    end
    check("pend_plots", 102, plots, 392);
    check("pend_placed", 102, np, 1);
    check("pend_rejected", 102, nr, 0);
    check("pend_last_busy", 102, last, 397);
    check("pend_cell", 102, int'(bus.cursor_cell), 2);

    // asynchronous reset in the middle of a draw, with a queued edge and a latched move
    @(negedge clk);
    bus.draw_cell = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) bus.draw_cell = 1'b0;
      if (k == 5) bus.plot_empty = 1'b1;
      if (k == 6) bus.plot_empty = 1'b0;
      if (k == 8) bus.move_right = 1'b1;
      if (k == 9) bus.move_right = 1'b0;
    end
    check("pre_reset_plot", 103, int'(bus.vga_plot), 1);
    #2 restart = 1'b1;
    #1;
    check("mid_reset_plot", 103, int'(bus.vga_plot), 0);
    check("mid_reset_busy", 103, int'(bus.busy), 0);
    @(negedge clk);
    restart = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_busy", 103, int'(bus.busy), 0);
    check("post_reset_col", 103, int'(bus.cursor_col), 0);
    check("post_reset_row", 103, int'(bus.cursor_row), 0);
    check("post_reset_cell", 103, int'(bus.cursor_cell), 0);
    run_vec(mk(EMP, 0, 4'b0000, 0, 0, 196, 199, 3'b001, 3'b010, 0, 0, 0, 0, 2'b00), 104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/board_render_datapath.md
Name: board_render_datapath

Overview:
- Datapath that responds to the game control FSM's command strobes: plot_empty, draw_cell, place_disk and turn_side.
- Holds the 8x8 Othello board state and the cursor position.
- Converts each accepted command into a per-pixel write stream for the VGA frame-buffer adapter (160x120, 3-bit colour).
- Sits between the control FSM and the VGA adapter. Also exports the cursor and board cell status for game-logic blocks.

Parameters:
CELL_PX, 14, cell side length in pixels (2..15)
ORIGIN_X, 24, x pixel of board top-left corner
ORIGIN_Y, 4, y pixel of board top-left corner

Ports:
clk  input  1  system clock
restart  input  1  asynchronous active-high reset
plot_empty  input  1  command: redraw cursor cell unhighlighted, then apply pending move
draw_cell  input  1  command: draw cursor cell highlighted
place_disk  input  1  command: place disk of turn_side at cursor
turn_side  input  1  0 = black, 1 = white; sampled when place_disk is accepted
move_up, move_down, move_left, move_right  input  1 each  cursor move requests (level)
vga_x  output  8  pixel x
vga_y  output  7  pixel y
vga_colour  output  3  pixel colour
vga_plot  output  1  pixel write enable
busy  output  1  job in progress
placed  output  1  one-cycle pulse: disk written
rejected  output  1  one-cycle pulse: place on occupied cell
cursor_col, cursor_row  output  3 each  current cursor
cursor_cell  output  2  board content at cursor: 00 empty, 01 black, 10 white

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Board empty except (row,col) (3,3),(4,4) = white and (3,4),(4,3) = black.
  - Cursor at (0,0). State IDLE. No pending command or move.
  - All outputs 0 except cursor_cell = 00.
- Command capture is rising-edge detected on each command input: a command is high this cycle and was low last cycle.
  - Held levels do not retrigger.
  - Several edges in the same cycle: priority place_disk > plot_empty > draw_cell. Lower-priority edges in that cycle are dropped.
- Pending slot, one deep:
  - An edge arriving while busy is stored in the slot. A later edge overwrites it, except that a stored place_disk is never overwritten.
  - The slot is serviced from IDLE on the cycle after DONE.
- Move latch:
  - Any move_* high sets a sticky bit for that direction.
  - The latched bits are applied and cleared in the DONE state of a plot_empty job: empty cell at the old position, highlight later at the new one.
  - up+down cancel; left+right cancel. Vertical and horizontal moves apply together (diagonal allowed).
  - Edge behaviour: saturate at 0 and 7.
- FSM states: IDLE -> LOAD (1 cycle: latch cursor, read cell, compute origin) -> DRAW (CELL_PX*CELL_PX cycles) -> DONE (1 cycle) -> IDLE.
  - busy is high in LOAD, DRAW and DONE.
- Latency:
  - Command edge seen at cycle N (sampled at the clock edge ending cycle N); LOAD occupies N+1.
  - vga_plot high for cycles N+2 .. N+1+CELL_PX^2.
  - busy falls in cycle N+3+CELL_PX^2.
- DRAW scan: raster order with px inner and py outer, both 0..CELL_PX-1.
  - vga_x = ORIGIN_X + col*CELL_PX + px; vga_y = ORIGIN_Y + row*CELL_PX + py.
  - Computed in 8 bits; no overflow at default parameters.
- Colour rules:
  - Border pixels (px==0, py==0, px==CELL_PX-1 or py==CELL_PX-1): 3'b001 for plot_empty, 3'b110 for draw_cell, 3'b110 for place_disk.
  - Interior pixels: empty 3'b010, black 3'b000, white 3'b111.
- place_disk:
  - In LOAD, if the cell is empty: write 01 (turn_side=0) or 10 (turn_side=1). Pulse placed in LOAD. DRAW the cell with its new content.
  - If the cell is occupied: pulse rejected in LOAD, go directly to DONE, no pixels.
- cursor_cell is combinational from the board and the cursor.
- Reset mid-job: vga_plot drops immediately; pending slot and move latch are cleared.

Optional Feature:
- CURSOR_WRAP_EN defined: cursor moves wrap modulo 8 (col 7 + right -> 0, row 0 + up -> 7).
- Undefined: moves saturate at 0 and 7.

Test Plan:
- Reset -> cursor (0,0); cursor_cell 00; cell (3,3) reads 10 and cell (3,4) reads 01 through cursor moves; busy=0, vga_plot=0.
- draw_cell edge at cursor (0,0) -> exactly 196 plots; x 24..37, y 4..17; border colour 110, interior 010; busy low 199 cycles after the edge.
- move_right pulse, then plot_empty edge, then draw_cell edge -> col0 redrawn with border 001, then col1 (x 38..51) highlighted; cursor_col=1.
- Cursor at (2,2), turn_side=1, place_disk -> placed pulse, cursor_cell=10, interior pixels 111; place_disk again -> rejected pulse, 0 plots.
- Cursor at col 7, move_right then plot_empty -> col stays 7 (wraps to 0 with CURSOR_WRAP_EN).
- draw_cell edge 10 cycles into a plot_empty job -> queued; serviced right after; 392 total plots, none lost.
